drink_order_scheduler: RTL
==========================

# drink_order_scheduler

Order queue and sequencer in front of the stepper/servo dispense path. Buffers drink requests (2-bit position codes) from the user-input logic in a small FIFO. Issues them one at a time to the stepper interface as a `select` strobe plus a stable `pos`. Waits for that interface's `complete` before starting the next order, with an optional watchdog.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `GAP_CYCLES`, 16: idle clk cycles enforced after each order ends, before the next `select`. Must be ≥1.
- `TIMEOUT_CYCLES`, 32'd500_000_000: watchdog limit in clk cycles, counted in WAIT_DONE. Used only with `DRINK_TIMEOUT_EN`.
- `clk`  in  1  system clock; the single clock of the block.
- `rst`  in  1  asynchronous, active-low reset.
- `order_valid`  in  1  request present this cycle.
- `order_pos`  in  2  requested drink position.
- `order_ready`  out  1  FIFO can accept; equals !full.
- `select`  out  1  one-cycle start strobe to the stepper interface.
- `pos`  out  2  position for the order in service.
- `complete`  in  1  done level from the stepper interface. Asynchronous to `clk`; synchronized internally.
- `done`  out  1  one-cycle pulse when an order finishes normally.
- `timeout_err`  out  1  one-cycle pulse when an order is abandoned by the watchdog.
- `busy`  out  1  high in every state except IDLE.
- `queue_count`  out  $clog2(DEPTH+1)  entries held in the FIFO. Excludes the order in service.

## Operation
- Push: an order is accepted on a clk edge with `order_valid & order_ready`. There is no bypass; when full, `order_ready` is 0 even if a pop occurs in the same cycle.
- Pop: occurs on the cycle the FSM leaves IDLE for ISSUE; the head entry is loaded into the `pos` register.
- A push and a pop in the same cycle leave `queue_count` unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate counter tracks occupancy.
- `complete` passes through a 2-FF synchronizer followed by a rising-edge detector, giving `cpl_rise`.
- FSM states and transitions:
  - IDLE: if `queue_count` != 0, pop and go to ISSUE.
  - ISSUE: `select`=1 for exactly this one cycle, then WAIT_DONE. Clears the watchdog counter.
  - WAIT_DONE: on `cpl_rise`, go to COOLDOWN and pulse `done` on the transition cycle. With the macro enabled, when the counter reaches TIMEOUT_CYCLES-1, go to COOLDOWN and pulse `timeout_err`.
  - COOLDOWN: count GAP_CYCLES cycles, then go to IDLE.
- `cpl_rise` outside WAIT_DONE is ignored. A `complete` level still high from the previous order never triggers completion; it must fall and rise again.
- If `cpl_rise` and the timeout occur in the same cycle, completion wins: `done`=1, `timeout_err`=0.
- `pos` holds its value from ISSUE through the end of COOLDOWN, and retains it in IDLE until the next pop.

## Timing
- Reset values: `select`=0, `pos`=0, `done`=0, `timeout_err`=0, `busy`=0, `queue_count`=0, `order_ready`=1. FSM in IDLE, FIFO pointers and all counters cleared, synchronizer flops 0.
- Reset asserted mid-operation:
  - all state is cleared immediately;
  - queued orders are discarded;
  - no `done` or `timeout_err` pulse is produced.
- Empty queue, order accepted at edge N: `queue_count`=1 after N. ISSUE begins at edge N+1, so `select` is high during cycle N+1 to N+2. `pos` is valid at the same edge as `select`.
- `complete` rising before edge M (meeting setup): `done` is high during the cycle following edge M+2, i.e. 3-cycle latency.
- Back-to-back orders: after `done`, the next `select` follows after GAP_CYCLES + 2 cycles (COOLDOWN + IDLE + ISSUE).
- `busy` is registered from the state and is high starting the cycle `select` is high.

## Configuration
- `DRINK_TIMEOUT_EN` defined:
  - a 32-bit watchdog counter runs in WAIT_DONE;
  - on expiry the order is dropped and `timeout_err` pulses;
  - the FSM proceeds to COOLDOWN and the queue continues.
- Not defined:
  - no counter is synthesized;
  - WAIT_DONE exits only on `cpl_rise`;
  - `timeout_err` is tied to 0.

## Test plan
- Reset, then one order with pos=2 pushed at edge N -> `select` is a 1-cycle pulse at N+1 with `pos`=2 and `busy`=1. Raise `complete` -> `done` pulses 3 cycles later. The block returns to IDLE GAP_CYCLES+1 cycles after `done`.
- Push 5 orders (0,1,2,3,1) back-to-back while stalled in WAIT_DONE, DEPTH=4 -> `order_ready` drops at `queue_count`=4 and the 5th order is not accepted. Service order is 0,1,2,3 on `pos`.
- Push and pop on the same cycle with `queue_count`=2 -> count stays 2. Pointers wrap after 4 pushes with no data corruption.
- `complete` held high across the end of one order and into the next -> the second order does not complete until `complete` falls and rises again.
- With `DRINK_TIMEOUT_EN` and TIMEOUT_CYCLES=20, `complete` never asserted -> `timeout_err` pulses 20 cycles after the ISSUE cycle, `done` stays 0, and the next queued order issues. Without the macro -> the block remains in WAIT_DONE indefinitely.
- `rst` driven low during WAIT_DONE with 3 orders queued -> all outputs at reset values immediately, `queue_count`=0, and no `select` after `rst` is released.

Source files
------------

// File: rtl/drink_order_scheduler.sv
// drink_order_scheduler: order FIFO and one-at-a-time sequencer for the dispense path; watchdog under DRINK_TIMEOUT_EN
module drink_order_scheduler #(
  parameter int          DEPTH          = 4,
  parameter int          GAP_CYCLES     = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         order_valid,
  input  logic [1:0]                   order_pos,
  output logic                         order_ready,
  output logic                         select,
  output logic [1:0]                   pos,
  input  logic                         complete,
  output logic                         done,
  output logic                         timeout_err,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = $clog2(GAP_CYCLES+1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COOLDOWN} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [1:0]      r_pos, r_sync;
  logic            r_sync_d, r_cpl_rise;
  logic [GW-1:0]   r_gap;
  logic            w_push, w_pop, w_gap_end, w_expire;
  assign order_ready = r_count != CW'(DEPTH);
  assign w_push      = order_valid & order_ready;
  assign w_pop       = r_state == IDLE && r_count != '0;
  assign w_gap_end   = r_state == COOLDOWN && r_gap == GW'(GAP_CYCLES - 1);
  assign pos         = r_pos;
  assign queue_count = r_count;
  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= order_pos;
  // FIFO pointers, occupancy, and the in-service position captured on pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_pos   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_pop) r_pos <= r_mem[r_rptr];
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  // Two-flop synchronizer on complete, then a registered rising-edge detector
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync     <= '0;
      r_sync_d   <= 1'b0;
      r_cpl_rise <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], complete};
      r_sync_d   <= r_sync[1];
      r_cpl_rise <= r_sync[1] & ~r_sync_d;
    end
  // Cooldown counter runs only while in COOLDOWN
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_gap <= '0;
    else r_gap <= (r_state == COOLDOWN) ? r_gap + 1'b1 : '0;
`ifdef DRINK_TIMEOUT_EN
  logic [31:0] r_wd;
  // Watchdog counts WAIT_DONE cycles and restarts from zero on every other state
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_wd <= '0;
    else r_wd <= (r_state == WAIT_DONE) ? r_wd + 32'd1 : '0;
  assign w_expire = r_state == WAIT_DONE && r_wd == TIMEOUT_CYCLES - 32'd1;
`else
  logic w_unused;
  assign w_unused = ^TIMEOUT_CYCLES;
  assign w_expire = 1'b0;
`endif
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  // Next state and state-decoded outputs; completion has priority over the watchdog
  always_comb begin
    w_next      = r_state;
    select      = r_state == ISSUE;
    busy        = r_state != IDLE;
    done        = r_state == WAIT_DONE && r_cpl_rise;
    timeout_err = r_state == WAIT_DONE && !r_cpl_rise && w_expire;
    case (r_state)
      IDLE:      w_next = w_pop ? ISSUE : IDLE;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: w_next = (r_cpl_rise || w_expire) ? COOLDOWN : WAIT_DONE;
      COOLDOWN:  w_next = w_gap_end ? IDLE : COOLDOWN;
    endcase
  end
endmodule
